// File: rtl/nibble_cpu_core.sv
// nibble_cpu_core: multi-register accumulator-style CPU that fetches 12-bit
// instructions as three 4-bit beats over a shared req/ready memory bus.
//
// Bus handshake: mem_req, mem_space, mem_addr, mem_we and mem_wdata are driven
// combinationally from registered state. A transfer completes on a rising clk
// edge where mem_req && mem_ready. Until then the FSM holds its state, so
// address and write data stay stable. mem_ready is ignored while mem_req is low.
module nibble_cpu_core #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 10,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic              mem_space,
  output logic [PC_W+1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [PC_W-1:0]   dbg_pc
);

  // Register index width: two registers use one index bit, four use two.
  localparam int RI_W = (NREGS == 4) ? 2 : 1;

  // One-hot FSM encoding.
  localparam logic [6:0] S_FETCH1 = 7'b0000001;
  localparam logic [6:0] S_FETCH2 = 7'b0000010;
  localparam logic [6:0] S_FETCH3 = 7'b0000100;
  localparam logic [6:0] S_EXEC   = 7'b0001000;
  localparam logic [6:0] S_LOAD   = 7'b0010000;
  localparam logic [6:0] S_STORE  = 7'b0100000;
  localparam logic [6:0] S_HALT   = 7'b1000000;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [6:0]        state;
  logic [6:0]        state_nxt;
  logic [PC_W-1:0]   pc;
  logic [3:0]        b1;
  logic [3:0]        b2;
  logic [3:0]        b3;
  logic [DATA_W-1:0] regs [NREGS];
  logic              z_flag;
  logic              c_flag;

  logic              bus_done;
  logic [1:0]        beat;
  logic [RI_W-1:0]   rd_i;
  logic [RI_W-1:0]   rs_i;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_wr;
  logic              c_upd;
  logic              jump_taken;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jump_target;

  // Decode fields; register indices wrap modulo NREGS by truncation.
  assign rd_i        = b2[RI_W+1:2];
  assign rs_i        = b2[RI_W-1:0];
  assign rd_val      = regs[rd_i];
  assign rs_val      = regs[rs_i];
  assign imm_ext     = DATA_W'(b3);
  assign pc_inc      = pc + PC_W'(1);
  assign jump_target = PC_W'({b2, b3});

  // Bus outputs decoded from the current state.
  always_comb begin
    mem_req   = (state == S_FETCH1) || (state == S_FETCH2) || (state == S_FETCH3) ||
                (state == S_LOAD)   || (state == S_STORE);
    mem_we    = (state == S_STORE);
    mem_space = (state == S_LOAD) || (state == S_STORE);
    beat      = 2'd0;
    if (state == S_FETCH2) beat = 2'd1;
    if (state == S_FETCH3) beat = 2'd2;
    mem_addr  = mem_space ? (PC_W+2)'(b3) : {pc, beat};
    mem_wdata = mem_we ? rs_val : '0;
    halted    = (state == S_HALT);
    dbg_pc    = pc;
  end

  assign bus_done = mem_req && mem_ready;

  // ALU and branch decision for the EXEC state.
  always_comb begin
    alu_res    = '0;
    alu_c      = c_flag;
    alu_wr     = 1'b0;
    c_upd      = 1'b0;
    jump_taken = 1'b0;
    wide       = '0;
    case (b1)
      OP_LDI: begin
        alu_res = imm_ext;
        alu_wr  = 1'b1;
      end
      OP_ADD: begin
        wide    = {1'b0, rd_val} + {1'b0, rs_val};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        alu_wr  = 1'b1;
        c_upd   = 1'b1;
      end
      OP_SUB: begin
        // Carry means "no borrow", i.e. rd >= rs.
        wide    = {1'b0, rd_val} - {1'b0, rs_val};
        alu_res = wide[DATA_W-1:0];
        alu_c   = ~wide[DATA_W];
        alu_wr  = 1'b1;
        c_upd   = 1'b1;
      end
      OP_AND: begin
        alu_res = rd_val & rs_val;
        alu_wr  = 1'b1;
      end
      OP_XOR: begin
        alu_res = rd_val ^ rs_val;
        alu_wr  = 1'b1;
      end
      OP_ADDI: begin
        wide    = {1'b0, rd_val} + {1'b0, imm_ext};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        alu_wr  = 1'b1;
        c_upd   = 1'b1;
      end
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = z_flag;
      OP_JC:   jump_taken = c_flag;
      default: ;
    endcase
  end

  // Next-state logic: bus states wait for a completed transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH1: if (bus_done) state_nxt = S_FETCH2;
      S_FETCH2: if (bus_done) state_nxt = S_FETCH3;
      S_FETCH3: begin
        if (bus_done) begin
          case (b1)
            OP_LD:   state_nxt = S_LOAD;
            OP_ST:   state_nxt = S_STORE;
            OP_HALT: state_nxt = S_HALT;
            default: state_nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC:  state_nxt = S_FETCH1;
      S_LOAD:  if (bus_done) state_nxt = S_FETCH1;
      S_STORE: if (bus_done) state_nxt = S_FETCH1;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH1;
    endcase
  end

  // State, pc, instruction beats, register file and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH1;
      pc     <= '0;
      b1     <= '0;
      b2     <= '0;
      b3     <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH1: if (bus_done) b1 <= mem_rdata[3:0];
        S_FETCH2: if (bus_done) b2 <= mem_rdata[3:0];
        S_FETCH3: if (bus_done) b3 <= mem_rdata[3:0];
        S_EXEC: begin
          pc <= jump_taken ? jump_target : pc_inc;
          if (alu_wr) begin
            regs[rd_i] <= alu_res;
            z_flag     <= (alu_res == '0);
          end
          if (c_upd) c_flag <= alu_c;
        end
        S_LOAD: begin
          if (bus_done) begin
            regs[rd_i] <= mem_rdata;
            z_flag     <= (mem_rdata == '0);
            pc         <= pc_inc;
          end
        end
        S_STORE: if (bus_done) pc <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Directed bench for nibble_cpu_core: a 4-bit instance (programs, flags,
// wait states, pc wrap, reset mid-store) and an 8-bit instance (LD).
module tb_nibble_cpu_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  // ---------------- DUT A: DATA_W=4 ----------------
  logic        req_a, ready_a, we_a, space_a, halted_a;
  logic [11:0] addr_a;
  logic [3:0]  wdata_a, rdata_a;
  logic [9:0]  pc_a;

  nibble_cpu_core #(.DATA_W(4), .PC_W(10), .NREGS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .mem_req(req_a), .mem_ready(ready_a),
    .mem_we(we_a), .mem_space(space_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .halted(halted_a), .dbg_pc(pc_a)
  );

  // ---------------- DUT B: DATA_W=8 ----------------
  logic        req_b, ready_b, we_b, space_b, halted_b;
  logic [11:0] addr_b;
  logic [7:0]  wdata_b, rdata_b;
  logic [9:0]  pc_b;

  nibble_cpu_core #(.DATA_W(8), .PC_W(10), .NREGS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .mem_req(req_b), .mem_ready(ready_b),
    .mem_we(we_b), .mem_space(space_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .halted(halted_b), .dbg_pc(pc_b)
  );

  // ---------------- memory models ----------------
  logic [11:0] prog_a [1024];
  logic [3:0]  dmem_a [16];
  logic [11:0] prog_b [64];
  logic [7:0]  dmem_b [16];

  logic stall_f2 = 1'b0;
  logic stall_st = 1'b0;
  int   st_cnt;

  function automatic logic [3:0] nib(input logic [11:0] w, input logic [1:0] beat);
    case (beat)
      2'd0:    return w[11:8];
      2'd1:    return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  assign rdata_a = space_a ? dmem_a[addr_a[3:0]] : nib(prog_a[addr_a[11:2]], addr_a[1:0]);
  // Upper fetch bits carry junk: only [3:0] may be used for instruction beats.
  assign rdata_b = space_b ? dmem_b[addr_b[3:0]] : {4'hC, nib(prog_b[addr_b[7:2]], addr_b[1:0])};
  assign ready_a = !((stall_f2 && !space_a && addr_a[1:0] == 2'd1 && st_cnt < 3) ||
                     (stall_st && we_a));
  assign ready_b = 1'b1;

  // ---------------- bus monitors ----------------
  logic [19:0] wr_q_a[$];
  logic [9:0]  f1_q_a[$];
  logic [19:0] wr_q_b[$];
  logic [9:0]  f1_q_b[$];
  int          stall_total = 0;
  int          addr_err = 0;
  logic        stalled;
  logic [11:0] stall_addr;
  int          space_cyc_b;
  int          load_cyc_b;

  always @(posedge clk) begin
    if (!rst_n_a) begin
      wr_q_a.delete();
      f1_q_a.delete();
      st_cnt  <= 0;
      stalled <= 1'b0;
    end else if (req_a) begin
      if (ready_a) begin
        if (we_a) wr_q_a.push_back({addr_a, 8'(wdata_a)});
        if (!space_a && addr_a[1:0] == 2'd0) f1_q_a.push_back(addr_a[11:2]);
        if (!space_a && addr_a[1:0] == 2'd1) st_cnt <= 0;
        stalled <= 1'b0;
      end else begin
        stall_total <= stall_total + 1;
        if (stalled && addr_a != stall_addr) addr_err <= addr_err + 1;
        stall_addr <= addr_a;
        stalled    <= 1'b1;
        if (!space_a && addr_a[1:0] == 2'd1) st_cnt <= st_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n_b) begin
      wr_q_b.delete();
      f1_q_b.delete();
      space_cyc_b <= 0;
      load_cyc_b  <= 0;
    end else begin
      if (space_b) space_cyc_b <= space_cyc_b + 1;
      if (space_b && !we_b && req_b) load_cyc_b <= load_cyc_b + 1;
      if (req_b && ready_b) begin
        if (we_b) wr_q_b.push_back({addr_b, wdata_b});
        if (!space_b && addr_b[1:0] == 2'd0) f1_q_b.push_back(addr_b[11:2]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_prog_a();
    for (int i = 0; i < 1024; i++) prog_a[i] = 12'h000;
    for (int i = 0; i < 16; i++) dmem_a[i] = 4'h0;
  endtask

  // Hold reset for two cycles, then release on a falling edge.
  task automatic pulse_reset_a();
    rst_n_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  // Cycle 1 is the cycle right after release; returns the first cycle in HALT.
  task automatic run_dut(input bit sel_b, input int limit, output int cyc);
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel_b ? halted_b : halted_a) && cyc < limit);
  endtask

  int cyc;
  int n_req;
  int st0;
  int ae0;
  int fsz;
  int exp_f3 [12] = '{'h000, 'h001, 'h002, 'h040, 'h041, 'h050,
                      'h051, 'h052, 'h053, 'h054, 'h055, 'h056};
  int exp_fw [5]  = '{'h3FE, 'h3FF, 'h000, 'h010, 'h011};

  initial begin
    clear_prog_a();
    for (int i = 0; i < 64; i++) prog_b[i] = 12'h000;
    for (int i = 0; i < 16; i++) dmem_b[i] = 8'h00;

    // ---- reset values ----
    @(negedge clk);
    chk("rst_req",   32'(req_a),   32'd1);
    chk("rst_space", 32'(space_a), 32'd0);
    chk("rst_addr",  32'(addr_a),  32'd0);
    chk("rst_we",    32'(we_a),    32'd0);
    chk("rst_wdata", 32'(wdata_a), 32'd0);
    chk("rst_halt",  32'(halted_a), 32'd0);
    chk("rst_pc",    32'(pc_a),    32'd0);

    // ---- zero-wait program: LDI r1,5; LDI r2,3; ADD r1,r2; ST r1,[2]; HALT ----
    prog_a[0] = 12'h145; prog_a[1] = 12'h183; prog_a[2] = 12'h460;
    prog_a[3] = 12'h312; prog_a[4] = 12'hF00;
    pulse_reset_a();
    run_dut(1'b0, 200, cyc);
    chk("p1_halted", 32'(halted_a), 32'd1);
    chk("p1_cycles", 32'(cyc), 32'd20);
    chk("p1_nwr", 32'(wr_q_a.size()), 32'd1);
    chk("p1_wr", 32'(wr_q_a[0]), 32'h00208);
    chk("p1_pc", 32'(pc_a), 32'd4);
    n_req = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_a) n_req++;
    end
    chk("p1_no_req_after_halt", 32'(n_req), 32'd0);

    // ---- same program, FETCH2 stalled 3 cycles per instruction ----
    rst_n_a = 1'b0;
    stall_f2 = 1'b1;
    st0 = stall_total;
    ae0 = addr_err;
    pulse_reset_a();
    run_dut(1'b0, 400, cyc);
    chk("p2_halted", 32'(halted_a), 32'd1);
    chk("p2_cycles", 32'(cyc), 32'd35);
    chk("p2_wr", 32'(wr_q_a[0]), 32'h00208);
    chk("p2_stalls", 32'(stall_total - st0), 32'd15);
    chk("p2_addr_stable", 32'(addr_err - ae0), 32'd0);
    stall_f2 = 1'b0;

    // ---- flags and branches ----
    rst_n_a = 1'b0;
    clear_prog_a();
    prog_a[12'h000] = 12'h10F;  // LDI r0,F
    prog_a[12'h001] = 12'h801;  // ADDI r0,1 -> 0, Z=1, C=1
    prog_a[12'h002] = 12'hB40;  // JC 0x40 (taken)
    prog_a[12'h040] = 12'h300;  // ST r0,[0]
    prog_a[12'h041] = 12'hA50;  // JZ 0x50 (taken, ST keeps flags)
    prog_a[12'h050] = 12'h143;  // LDI r1,3
    prog_a[12'h051] = 12'h185;  // LDI r2,5
    prog_a[12'h052] = 12'h560;  // SUB r1,r2 -> E, C=0, Z=0
    prog_a[12'h053] = 12'h311;  // ST r1,[1]
    prog_a[12'h054] = 12'hB20;  // JC 0x20 (not taken)
    prog_a[12'h055] = 12'hA10;  // JZ 0x10 (not taken)
    prog_a[12'h056] = 12'hF00;  // HALT
    pulse_reset_a();
    run_dut(1'b0, 400, cyc);
    chk("p3_halted", 32'(halted_a), 32'd1);
    chk("p3_nfetch", 32'(f1_q_a.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("p3_fetch%0d", i), 32'(f1_q_a[i]), 32'(exp_f3[i]));
    chk("p3_nwr", 32'(wr_q_a.size()), 32'd2);
    chk("p3_wr_r0", 32'(wr_q_a[0]), 32'h00000);
    chk("p3_wr_sub", 32'(wr_q_a[1]), 32'h0010E);
    chk("p3_pc", 32'(pc_a), 32'h056);

    // ---- pc wrap at 2^PC_W-1 ----
    rst_n_a = 1'b0;
    clear_prog_a();
    prog_a[12'h000] = 12'hB10;  // JC 0x10: C=0 first pass, C=1 after wrap
    prog_a[12'h001] = 12'h9FF;  // JMP 0xFF
    prog_a[12'h3FE] = 12'h10F;  // LDI r0,F
    prog_a[12'h3FF] = 12'h801;  // ADDI r0,1 -> C=1
    prog_a[12'h010] = 12'h300;  // ST r0,[0]
    prog_a[12'h011] = 12'hF00;  // HALT
    pulse_reset_a();
    run_dut(1'b0, 6000, cyc);
    chk("p4_halted", 32'(halted_a), 32'd1);
    fsz = f1_q_a.size();
    chk("p4_nfetch", 32'(fsz), 32'd774);
    for (int i = 0; i < 5; i++) chk($sformatf("p4_tail%0d", i), 32'(f1_q_a[fsz-5+i]), 32'(exp_fw[i]));
    chk("p4_wr", 32'(wr_q_a[0]), 32'h00000);

    // ---- LD on the 8-bit core ----
    prog_b[0] = 12'h287;  // LD r2,[7]
    prog_b[1] = 12'h323;  // ST r2,[3]
    prog_b[2] = 12'hA20;  // JZ 0x20 (not taken, Z=0)
    prog_b[3] = 12'hF00;  // HALT
    prog_b[32] = 12'h309; // only reached if JZ wrongly taken
    dmem_b[7] = 8'hA5;
    @(negedge clk);
    rst_n_b = 1'b1;
    run_dut(1'b1, 200, cyc);
    chk("p5_halted", 32'(halted_b), 32'd1);
    chk("p5_nwr", 32'(wr_q_b.size()), 32'd1);
    chk("p5_wr", 32'(wr_q_b[0]), 32'h003A5);
    chk("p5_nfetch", 32'(f1_q_b.size()), 32'd4);
    chk("p5_last_fetch", 32'(f1_q_b[3]), 32'd3);
    chk("p5_load_cycles", 32'(load_cyc_b), 32'd1);
    chk("p5_space_cycles", 32'(space_cyc_b), 32'd2);

    // ---- reset during a stalled STORE ----
    rst_n_a = 1'b0;
    clear_prog_a();
    prog_a[0] = 12'h147;  // LDI r1,7
    prog_a[1] = 12'h315;  // ST r1,[5] (stalled)
    stall_st = 1'b1;
    pulse_reset_a();
    cyc = 0;
    while (!we_a && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk("p6_store_pending", 32'(we_a), 32'd1);
    chk("p6_store_addr", 32'(addr_a), 32'd5);
    chk("p6_store_data", 32'(wdata_a), 32'd7);
    #2 rst_n_a = 1'b0;
    #1;
    chk("p6_we_async", 32'(we_a), 32'd0);
    chk("p6_req_async", 32'(req_a), 32'd1);
    chk("p6_addr_async", 32'(addr_a), 32'd0);
    chk("p6_wdata_async", 32'(wdata_a), 32'd0);
    chk("p6_no_write", 32'(wr_q_a.size()), 32'd0);
    stall_st = 1'b0;
    prog_a[0] = 12'h316;  // ST r1,[6] -> must store 0
    prog_a[1] = 12'hF00;
    @(negedge clk);
    pulse_reset_a();
    run_dut(1'b0, 200, cyc);
    chk("p6_halted", 32'(halted_a), 32'd1);
    chk("p6_cycles", 32'(cyc), 32'd8);
    chk("p6_first_fetch", 32'(f1_q_a[0]), 32'd0);
    chk("p6_wr", 32'(wr_q_a[0]), 32'h00600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
